// File: rtl/spmv_rr_dispatch.sv
// spmv_rr_dispatch
//   Round-robin dispatcher. Beats from a single valid/ready input stream are
//   spread across NUM_LANES consumer lanes, each of which has a one-entry
//   output register. Frames are delimited by in_last. After the final beat
//   the block stops accepting, waits for every lane to drain, and then pulses
//   frame_done for one cycle.
//
// Ports
//   clk        clock
//   rstn       synchronous, active-low reset
//   in_valid   input beat valid
//   in_data    input payload (DATA_WIDTH)
//   in_last    final beat of the frame
//   in_ready   a beat is accepted this cycle when in_valid is also high
//   out_valid  per-lane valid, bit i belongs to lane i
//   out_data   lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//   out_last   per-lane copy of in_last
//   out_ready  per-lane consumer ready
//   beat_cnt   beats accepted in the current frame (saturating)
//   frame_done one-cycle pulse once a frame has fully drained
//   stall_cnt  (only with SPMV_DISPATCH_STALL_CNT_EN) cycles in which a beat
//              was offered while running but could not be taken (saturating)
//
// Optional build macro: SPMV_DISPATCH_STALL_CNT_EN
module spmv_rr_dispatch #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [NUM_LANES-1:0]            out_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]            out_last,
  input  logic [NUM_LANES-1:0]            out_ready,
  output logic [CNT_WIDTH-1:0]            beat_cnt,
  output logic                            frame_done
`ifdef SPMV_DISPATCH_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]            stall_cnt
`endif
);

  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]            state_reg;
  logic [PTR_W-1:0]      ptr_reg;
  logic [NUM_LANES-1:0]  lv_reg;
  logic [NUM_LANES-1:0]  last_reg;
  logic [DATA_WIDTH-1:0] data_reg [NUM_LANES];
  logic [CNT_WIDTH-1:0]  beat_cnt_reg;

  // cand[g] is the lane visited g steps after ptr in the round-robin scan.
  logic [PTR_W-1:0]      cand [NUM_LANES];
  logic [NUM_LANES-1:0]  cand_free;
  logic [PTR_W-1:0]      sel;
  logic [PTR_W-1:0]      ptr_next;
  logic                  any_free;
  logic                  accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [PTR_W:0] sum;
      // ptr is always < NUM_LANES, so one conditional subtract is an exact
      // modulo, also for non-power-of-two lane counts.
      assign sum = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
      assign cand[gi] = (sum >= (PTR_W+1)'(NUM_LANES))
                        ? PTR_W'(sum - (PTR_W+1)'(NUM_LANES))
                        : sum[PTR_W-1:0];
      // Freeness comes from registered state only, so out_ready never
      // reaches in_ready combinationally and a draining lane is not free.
      assign cand_free[gi] = ~lv_reg[cand[gi]];
      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg[gi];
    end
  endgenerate

  // First free lane in scan order: iterate from the far end so the nearest
  // candidate wins.
  always_comb begin
    sel = ptr_reg;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (cand_free[k]) sel = cand[k];
    end
  end

  assign any_free   = |(~lv_reg);
  assign in_ready   = rstn & (state_reg == ST_RUN) & any_free;
  assign accept     = in_valid & in_ready;
  assign ptr_next   = (sel == LAST_LANE) ? '0 : sel + PTR_W'(1);

  assign out_valid  = lv_reg;
  assign out_last   = last_reg;
  assign beat_cnt   = beat_cnt_reg;
  assign frame_done = (state_reg == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= ST_RUN;
      ptr_reg      <= '0;
      lv_reg       <= '0;
      last_reg     <= '0;
      beat_cnt_reg <= '0;
      for (int k = 0; k < NUM_LANES; k++) data_reg[k] <= '0;
    end else begin
      // A selected lane is free, so load and drain never hit the same lane.
      for (int k = 0; k < NUM_LANES; k++) begin
        if (accept && (sel == PTR_W'(k))) begin
          lv_reg[k]   <= 1'b1;
          data_reg[k] <= in_data;
          last_reg[k] <= in_last;
        end else if (lv_reg[k] && out_ready[k]) begin
          lv_reg[k] <= 1'b0;   // data/last keep their value after draining
        end
      end

      case (state_reg)
        ST_RUN: begin
          if (accept) begin
            ptr_reg <= ptr_next;
            if (beat_cnt_reg != '1) beat_cnt_reg <= beat_cnt_reg + CNT_WIDTH'(1);
            if (in_last) state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (lv_reg == '0) state_reg <= ST_DONE;
        end
        ST_DONE: begin
          ptr_reg      <= '0;
          beat_cnt_reg <= '0;
          state_reg    <= ST_RUN;
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

`ifdef SPMV_DISPATCH_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == ST_DONE) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == ST_RUN) && in_valid && !in_ready &&
                 (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
